// File: rtl/fifo_rr_arbiter.sv
// Round-robin write arbiter feeding a shared FIFO, with a single-entry
// valid/ready output register on the read side that tags each word with its source.
module fifo_rr_arbiter #(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 8,
    localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [ID_W+DATA_WIDTH-1:0]     fifo_din,
    output logic                           fifo_push,
    input  logic                           fifo_full,
    input  logic [ID_W+DATA_WIDTH-1:0]     fifo_dout,
    output logic                           fifo_pop,
    input  logic                           fifo_empty,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [ID_W-1:0]                out_id,
    input  logic                           out_ready
);

    logic [ID_W-1:0]       last_grant;
    logic [ID_W-1:0]       win_id;
    logic                  found;
    logic [NUM_REQ-1:0]    grant;
    logic                  load;
    logic [DATA_WIDTH-1:0] slot [NUM_REQ];

    // Unflatten the requester payloads
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slot[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Rotating priority search starting just after the last winner
    always_comb begin
        int idx;
        found  = 1'b0;
        win_id = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % int'(NUM_REQ);
            if (!found && req_valid[ID_W'(idx)]) begin
                found  = 1'b1;
                win_id = ID_W'(idx);
            end
        end
    end

    // Grant only when there is room; reset masks every handshake
    always_comb begin
        grant = '0;
        if (found && !fifo_full && !reset) begin
            grant[win_id] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign fifo_push = |grant;
    assign fifo_din  = fifo_push ? {win_id, slot[win_id]} : '0;

    assign load     = !fifo_empty && (!out_valid || out_ready) && !reset;
    assign fifo_pop = load;

    // Grant pointer and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= '0;
        end else begin
            if (fifo_push) begin
                last_grant <= win_id;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= fifo_dout[DATA_WIDTH-1:0];
                out_id    <= fifo_dout[ID_W+DATA_WIDTH-1 -: ID_W];
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter with a 4-deep FIFO model attached.
module tb_fifo_rr_arbiter;

    localparam int unsigned NR    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned IW    = 2;
    localparam int unsigned DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NR-1:0]        req_valid;
    logic [NR*DW-1:0]     req_data;
    logic [NR-1:0]        req_ready;
    logic [IW+DW-1:0]     fifo_din;
    logic                 fifo_push;
    logic                 fifo_full;
    logic [IW+DW-1:0]     fifo_dout;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [IW-1:0]        out_id;
    logic                 out_ready;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_din(fifo_din), .fifo_push(fifo_push), .fifo_full(fifo_full),
        .fifo_dout(fifo_dout), .fifo_pop(fifo_pop), .fifo_empty(fifo_empty),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready)
    );

    // FIFO model, reset from !reset like the real integration
    logic [IW+DW-1:0] fmem [DEPTH];
    logic [1:0]       wp, rp;
    logic [2:0]       cnt;
    logic             fifo_resetn;
    logic             do_push, do_pop;

    assign fifo_resetn = !reset;
    assign fifo_full   = (cnt == 3'(DEPTH));
    assign fifo_empty  = (cnt == 3'd0);
    assign fifo_dout   = fmem[rp];
    assign do_push     = fifo_push && !fifo_full;
    assign do_pop      = fifo_pop && !fifo_empty;

    always_ff @(posedge clk) begin
        if (!fifo_resetn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                fmem[wp] <= fifo_din;
                wp       <= wp + 2'd1;
            end
            if (do_pop) rp <= rp + 2'd1;
            cnt <= cnt + 3'(do_push) - 3'(do_pop);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = base + 8'(i);
    endtask

    initial begin
        int acc;
        logic [3:0] skip_rdy [4];
        int         skip_id  [4];
        int         drain_id [4];
        int         mid_rdy  [3];
        skip_rdy = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        skip_id  = '{2, 3, 1, 3};
        drain_id = '{1, 2, 3, 0};
        mid_rdy  = '{8, 1, 2};

        // Reset with every requester asking
        reset     = 1'b1;
        req_valid = 4'hF;
        out_ready = 1'b1;
        set_data(8'hA0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_ready", 32'(req_ready), 32'h0);
            check("rst_push",  32'(fifo_push), 32'h0);
            check("rst_pop",   32'(fifo_pop),  32'h0);
            check("rst_valid", 32'(out_valid), 32'h0);
            check("rst_id",    32'(out_id),    32'h0);
        end
        tick();
        reset = 1'b0;

        // Round robin with all requesters, out_id lags grants by 2 cycles
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("rr_ready", 32'(req_ready), 32'(4'b0001 << (c % 4)));
            check("rr_din",   32'(fifo_din),  32'({2'(c % 4), 8'(8'hA0 + 8'(c % 4))}));
            if (c < 2) begin
                check("rr_valid0", 32'(out_valid), 32'h0);
            end else begin
                check("rr_valid", 32'(out_valid), 32'h1);
                check("rr_id",    32'(out_id),    32'((c - 2) % 4));
                check("rr_data",  32'(out_data),  32'(8'hA0 + 8'((c - 2) % 4)));
            end
            tick();
        end

        // Idle requesters 0 and 2 are skipped
        req_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("skip_ready", 32'(req_ready), 32'(skip_rdy[c]));
            check("skip_id",    32'(out_id),    32'(skip_id[c]));
            tick();
        end
        req_valid = 4'b0000;
        for (int c = 0; c < 4; c++) tick();
        @(negedge clk);
        check("drain_valid", 32'(out_valid),  32'h0);
        check("drain_empty", 32'(fifo_empty), 32'h1);
        tick();

        // Back-pressure: DEPTH words in FIFO plus one held in the output register
        req_valid = 4'hF;
        out_ready = 1'b0;
        set_data(8'hB0);
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (fifo_full) check("push_full", 32'(fifo_push), 32'h0);
            if (fifo_push) acc++;
            tick();
        end
        @(negedge clk);
        check("bp_accepted", 32'(acc),       32'(DEPTH + 1));
        check("bp_full",     32'(fifo_full), 32'h1);
        check("bp_hold_id",  32'(out_id),    32'h0);
        check("bp_hold_dat", 32'(out_data),  32'hB0);

        // Pop while full still refuses a push that cycle
        out_ready = 1'b1;
        #1;
        check("fullpop_ready", 32'(req_ready), 32'h0);
        check("fullpop_pop",   32'(fifo_pop),  32'h1);
        tick();
        req_valid = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'h1);
            check("bp_id",    32'(out_id),    32'(drain_id[r]));
            check("bp_data",  32'(out_data),  32'(8'hB0 + 8'(drain_id[r])));
            tick();
        end
        @(negedge clk);
        check("bp_done", 32'(out_valid), 32'h0);
        tick();

        // Stall stability: single word from requester 2, ready 0,0,1
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 8'hC5;
        out_ready = 1'b0;
        @(negedge clk);
        check("st_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        tick();
        for (int s = 0; s < 3; s++) begin
            out_ready = (s == 2);
            @(negedge clk);
            check("st_valid", 32'(out_valid), 32'h1);
            check("st_id",    32'(out_id),    32'h2);
            check("st_data",  32'(out_data),  32'hC5);
            tick();
        end
        out_ready = 1'b0;
        @(negedge clk);
        check("st_consumed", 32'(out_valid), 32'h0);
        tick();

        // Mid-stream reset with three words queued
        req_valid = 4'hF;
        set_data(8'hD0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_ready", 32'(req_ready), 32'(mid_rdy[c]));
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        check("mid_rst_push",  32'(fifo_push), 32'h0);
        check("mid_rst_pop",   32'(fifo_pop),  32'h0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_valid", 32'(out_valid),  32'h0);
        check("mid_empty", 32'(fifo_empty), 32'h1);
        check("mid_first", 32'(req_ready),  32'b0001);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
